// File: rtl/nes_mem_pkg.sv
// Shared definitions for the NES unified memory bus: FSM encoding, address regions
// and the default read-hold length used by nes_mem_master and the main_mem bench.
package nes_mem_pkg;

    localparam int NES_READ_HOLD = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_CAP  = 2'd2;
    localparam logic [1:0] ST_WR   = 2'd3;

    typedef enum logic [2:0] {
        REG_PRG,
        REG_CHR,
        REG_VRAM,
        REG_CPURAM,
        REG_CARTRAM,
        REG_NONE
    } region_e;

    // Region map is decoded from the top address bits of the 22-bit logical address.
    function automatic region_e region_of(input logic [21:0] addr);
        region_e r;
        casez (addr[21:18])
            4'b0???: r = REG_PRG;
            4'b10??: r = REG_CHR;
            4'b1100: r = REG_VRAM;
            4'b1110: r = REG_CPURAM;
            4'b1111: r = REG_CARTRAM;
            default: r = REG_NONE;
        endcase
        return r;
    endfunction

    function automatic logic is_prg(input logic [21:0] addr);
        return (addr[21] == 1'b0);
    endfunction

endpackage

// File: rtl/nes_mem_arb.sv
// Two-way CPU/PPU arbiter: masks requesters whose ack is showing this cycle and
// picks fixed-priority PPU or round-robin on the last grant.
module nes_mem_arb #(
    parameter int PPU_PRIORITY = 1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic enable_i,
    input  logic cpu_req_i,
    input  logic cpu_ack_i,
    input  logic ppu_req_i,
    input  logic ppu_ack_i,
    output logic grant_valid_o,
    output logic grant_ppu_o
);

    logic last_ppu_q;
    logic cpu_elig;
    logic ppu_elig;

    // A requester keeps req high through its ack cycle, so it is ineligible while its ack shows.
    assign cpu_elig = cpu_req_i & ~cpu_ack_i;
    assign ppu_elig = ppu_req_i & ~ppu_ack_i;

    assign grant_valid_o = enable_i & (cpu_elig | ppu_elig);
    assign grant_ppu_o   = ppu_elig & (~cpu_elig | (PPU_PRIORITY != 0) | ~last_ppu_q);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_ppu_q <= 1'b0;
        end else if (grant_valid_o) begin
            last_ppu_q <= grant_ppu_o;
        end
    end

endmodule

// File: rtl/nes_mem_master.sv
// Initiator for the NES unified memory bus: arbitrates CPU/PPU requests and sequences
// them onto main_mem's single strobe bus, holding reads for the registered read path.
module nes_mem_master
    import nes_mem_pkg::*;
#(
    parameter int READ_HOLD    = NES_READ_HOLD,
    parameter int PPU_PRIORITY = 1,
    parameter int PROTECT_PRG  = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        load_done,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [21:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    input  logic        ppu_req,
    input  logic        ppu_we,
    input  logic [21:0] ppu_addr,
    input  logic [7:0]  ppu_wdata,
    output logic        ppu_ack,
    output logic [7:0]  ppu_rdata,
    output logic [21:0] mem_addr,
    output logic        mem_rd_cpu,
    output logic        mem_rd_ppu,
    output logic        mem_wr,
    output logic [7:0]  mem_d,
    input  logic [7:0]  mem_q_cpu,
    input  logic [7:0]  mem_q_ppu,
    output logic [1:0]  dbg_state
);

    // Handshake: a requester raises req with we/addr/wdata stable and holds it until it sees
    // a one-cycle ack; the ack cycle itself never grants that requester again.
    logic [1:0]  state_q, state_d;
    logic [3:0]  hold_q, hold_d;
    logic        src_ppu_q, src_ppu_d;
    logic [21:0] addr_q, addr_d;
    logic [7:0]  wdat_q, wdat_d;
    logic        rd_cpu_q, rd_cpu_d, rd_ppu_q, rd_ppu_d, wr_q, wr_d;
    logic        cpu_ack_q, cpu_ack_d, ppu_ack_q, ppu_ack_d;
    logic [7:0]  cpu_rdata_q, cpu_rdata_d, ppu_rdata_q, ppu_rdata_d;

    logic        grant_valid, grant_ppu;
    logic        sel_we;
    logic [21:0] sel_addr;
    logic [7:0]  sel_wdata;

    nes_mem_arb #(.PPU_PRIORITY(PPU_PRIORITY)) u_arb (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable_i     ((state_q == ST_IDLE) && load_done),
        .cpu_req_i    (cpu_req),
        .cpu_ack_i    (cpu_ack_q),
        .ppu_req_i    (ppu_req),
        .ppu_ack_i    (ppu_ack_q),
        .grant_valid_o(grant_valid),
        .grant_ppu_o  (grant_ppu)
    );

    assign sel_we    = grant_ppu ? ppu_we    : cpu_we;
    assign sel_addr  = grant_ppu ? ppu_addr  : cpu_addr;
    assign sel_wdata = grant_ppu ? ppu_wdata : cpu_wdata;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        src_ppu_d   = src_ppu_q;
        addr_d      = addr_q;
        wdat_d      = wdat_q;
        rd_cpu_d    = 1'b0;
        rd_ppu_d    = 1'b0;
        wr_d        = 1'b0;
        cpu_ack_d   = 1'b0;
        ppu_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        ppu_rdata_d = ppu_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    src_ppu_d = grant_ppu;
                    addr_d    = sel_addr;
                    hold_d    = 4'd0;
                    if (sel_we) begin
                        state_d = ST_WR;
                        wdat_d  = sel_wdata;
                        // Protected PRG writes still run the full write cycle, just without the strobe.
                        wr_d    = !((PROTECT_PRG != 0) && is_prg(sel_addr));
                    end else begin
                        state_d  = ST_RD;
                        rd_cpu_d = !grant_ppu;
                        rd_ppu_d = grant_ppu;
                    end
                end
            end
            ST_RD: begin
                if (hold_q == 4'(READ_HOLD - 1)) begin
                    state_d = ST_CAP;
                end else begin
                    hold_d   = hold_q + 4'd1;
                    rd_cpu_d = !src_ppu_q;
                    rd_ppu_d = src_ppu_q;
                end
            end
            ST_CAP: begin
                state_d = ST_IDLE;
                if (src_ppu_q) begin
                    ppu_rdata_d = mem_q_ppu;
                    ppu_ack_d   = 1'b1;
                end else begin
                    cpu_rdata_d = mem_q_cpu;
                    cpu_ack_d   = 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cpu_ack_d = !src_ppu_q;
                ppu_ack_d = src_ppu_q;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            hold_q      <= 4'd0;
            src_ppu_q   <= 1'b0;
            addr_q      <= 22'd0;
            wdat_q      <= 8'd0;
            rd_cpu_q    <= 1'b0;
            rd_ppu_q    <= 1'b0;
            wr_q        <= 1'b0;
            cpu_ack_q   <= 1'b0;
            ppu_ack_q   <= 1'b0;
            cpu_rdata_q <= 8'd0;
            ppu_rdata_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            src_ppu_q   <= src_ppu_d;
            addr_q      <= addr_d;
            wdat_q      <= wdat_d;
            rd_cpu_q    <= rd_cpu_d;
            rd_ppu_q    <= rd_ppu_d;
            wr_q        <= wr_d;
            cpu_ack_q   <= cpu_ack_d;
            ppu_ack_q   <= ppu_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            ppu_rdata_q <= ppu_rdata_d;
        end
    end

    assign mem_addr   = addr_q;
    assign mem_d      = wdat_q;
    assign mem_rd_cpu = rd_cpu_q;
    assign mem_rd_ppu = rd_ppu_q;
    assign mem_wr     = wr_q;
    assign cpu_ack    = cpu_ack_q;
    assign ppu_ack    = ppu_ack_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign ppu_rdata  = ppu_rdata_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_nes_mem_master.sv
// Directed bench for nes_mem_master: a PPU-priority instance and a round-robin instance,
// each backed by a two-stage registered memory model.
module tb_nes_mem_master;
    import nes_mem_pkg::*;

    int compared;
    int mismatched;
    int wr_pulses;

    logic clock;
    logic reset_n;
    logic load_done;

    // Default instance (PPU priority)
    logic        cpu_req, cpu_we, cpu_ack, ppu_req, ppu_we, ppu_ack;
    logic [21:0] cpu_addr, ppu_addr, mem_addr;
    logic [7:0]  cpu_wdata, cpu_rdata, ppu_wdata, ppu_rdata, mem_d, mem_q_cpu, mem_q_ppu;
    logic        mem_rd_cpu, mem_rd_ppu, mem_wr;
    logic [1:0]  dbg_state;

    // Round-robin instance
    logic        r_cpu_req, r_cpu_we, r_cpu_ack, r_ppu_req, r_ppu_we, r_ppu_ack;
    logic [21:0] r_cpu_addr, r_ppu_addr, r_mem_addr;
    logic [7:0]  r_cpu_wdata, r_cpu_rdata, r_ppu_wdata, r_ppu_rdata, r_mem_d, r_mem_q_cpu, r_mem_q_ppu;
    logic        r_mem_rd_cpu, r_mem_rd_ppu, r_mem_wr;
    logic [1:0]  r_dbg_state;

    nes_mem_master dut (
        .clock(clock), .reset_n(reset_n), .load_done(load_done),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ppu_req(ppu_req), .ppu_we(ppu_we), .ppu_addr(ppu_addr), .ppu_wdata(ppu_wdata),
        .ppu_ack(ppu_ack), .ppu_rdata(ppu_rdata),
        .mem_addr(mem_addr), .mem_rd_cpu(mem_rd_cpu), .mem_rd_ppu(mem_rd_ppu),
        .mem_wr(mem_wr), .mem_d(mem_d), .mem_q_cpu(mem_q_cpu), .mem_q_ppu(mem_q_ppu),
        .dbg_state(dbg_state)
    );

    nes_mem_master #(.PPU_PRIORITY(0)) dut_rr (
        .clock(clock), .reset_n(reset_n), .load_done(load_done),
        .cpu_req(r_cpu_req), .cpu_we(r_cpu_we), .cpu_addr(r_cpu_addr), .cpu_wdata(r_cpu_wdata),
        .cpu_ack(r_cpu_ack), .cpu_rdata(r_cpu_rdata),
        .ppu_req(r_ppu_req), .ppu_we(r_ppu_we), .ppu_addr(r_ppu_addr), .ppu_wdata(r_ppu_wdata),
        .ppu_ack(r_ppu_ack), .ppu_rdata(r_ppu_rdata),
        .mem_addr(r_mem_addr), .mem_rd_cpu(r_mem_rd_cpu), .mem_rd_ppu(r_mem_rd_ppu),
        .mem_wr(r_mem_wr), .mem_d(r_mem_d), .mem_q_cpu(r_mem_q_cpu), .mem_q_ppu(r_mem_q_ppu),
        .dbg_state(r_dbg_state)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory models: sync RAM stage then output register; initial content = low addr byte ^ 0x3C
    logic [7:0] mem0 [0:4095];
    logic [7:0] mem1 [0:4095];
    logic [7:0] s1c0, s1p0, s1c1, s1p1;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem0[i] <= 8'(i) ^ 8'h3C;
            mem1[i] <= 8'(i) ^ 8'h3C;
        end
        s1c0 <= 8'h0; s1p0 <= 8'h0; s1c1 <= 8'h0; s1p1 <= 8'h0;
        mem_q_cpu <= 8'h0; mem_q_ppu <= 8'h0; r_mem_q_cpu <= 8'h0; r_mem_q_ppu <= 8'h0;
    end

    always @(posedge clock) begin
        if (mem_wr) mem0[mem_addr[11:0]] <= mem_d;
        if (mem_rd_cpu) s1c0 <= mem0[mem_addr[11:0]];
        if (mem_rd_ppu) s1p0 <= mem0[mem_addr[11:0]];
        mem_q_cpu <= s1c0;
        mem_q_ppu <= s1p0;
        if (r_mem_wr) mem1[r_mem_addr[11:0]] <= r_mem_d;
        if (r_mem_rd_cpu) s1c1 <= mem1[r_mem_addr[11:0]];
        if (r_mem_rd_ppu) s1p1 <= mem1[r_mem_addr[11:0]];
        r_mem_q_cpu <= s1c1;
        r_mem_q_ppu <= s1p1;
    end

    // Strobe monitor: at most one strobe, none in IDLE/CAP; also counts write pulses
    always @(negedge clock) begin
        if (mem_wr) wr_pulses++;
        compared++;
        if (($countones({mem_rd_cpu, mem_rd_ppu, mem_wr}) > 1) ||
            ((dbg_state == ST_IDLE || dbg_state == ST_CAP) && (mem_rd_cpu | mem_rd_ppu | mem_wr))) begin
            mismatched++;
            $display("FAIL strobe_excl t=%0t: rd_cpu=%b rd_ppu=%b wr=%b state=%0d", $time,
                     mem_rd_cpu, mem_rd_ppu, mem_wr, dbg_state);
        end
        compared++;
        if (($countones({r_mem_rd_cpu, r_mem_rd_ppu, r_mem_wr}) > 1) ||
            ((r_dbg_state == ST_IDLE || r_dbg_state == ST_CAP) && (r_mem_rd_cpu | r_mem_rd_ppu | r_mem_wr))) begin
            mismatched++;
            $display("FAIL rr_strobe_excl t=%0t: rd_cpu=%b rd_ppu=%b wr=%b state=%0d", $time,
                     r_mem_rd_cpu, r_mem_rd_ppu, r_mem_wr, r_dbg_state);
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cpu_access(input logic we, input logic [21:0] addr, input logic [7:0] wdata,
                              output int lat, output logic [7:0] rdata);
        cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (cpu_ack) begin lat = i; break; end
        end
        rdata = cpu_rdata;
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic ppu_access(input logic we, input logic [21:0] addr, input logic [7:0] wdata,
                              output int lat, output logic [7:0] rdata);
        ppu_we = we; ppu_addr = addr; ppu_wdata = wdata; ppu_req = 1'b1;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (ppu_ack) begin lat = i; break; end
        end
        rdata = ppu_rdata;
        ppu_req = 1'b0;
        tick();
    endtask

    // Scenarios
    task automatic test_reset();
        repeat (3) tick();
        compared++;
        if ({mem_rd_cpu, mem_rd_ppu, mem_wr, cpu_ack, ppu_ack} !== 5'b0) begin
            mismatched++;
            $display("FAIL reset_strobes: got %b want 00000", {mem_rd_cpu, mem_rd_ppu, mem_wr, cpu_ack, ppu_ack});
        end
        compared++;
        if ({mem_addr, mem_d, cpu_rdata, ppu_rdata} !== 46'h0) begin
            mismatched++;
            $display("FAIL reset_data: got addr=%h d=%h crd=%h prd=%h want 0", mem_addr, mem_d, cpu_rdata, ppu_rdata);
        end
        compared++;
        if (dbg_state !== ST_IDLE || r_dbg_state !== ST_IDLE) begin
            mismatched++;
            $display("FAIL reset_state: got %0d/%0d want 0/0", dbg_state, r_dbg_state);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_load_gate();
        int act;
        int lat;
        act = 0;
        cpu_we = 1'b0; cpu_addr = 22'h380010; cpu_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mem_rd_cpu | mem_rd_ppu | mem_wr | cpu_ack) act++;
        end
        compared++;
        if (act !== 0) begin
            mismatched++;
            $display("FAIL load_gate_idle: got %0d active cycles want 0", act);
        end
        load_done = 1'b1;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (cpu_ack) begin lat = i; break; end
        end
        compared++;
        if (lat !== 4) begin
            mismatched++;
            $display("FAIL load_gate_latency: got %0d want 4", lat);
        end
        compared++;
        if (cpu_rdata !== 8'h2C) begin
            mismatched++;
            $display("FAIL load_gate_rdata: got %h want 2c", cpu_rdata);
        end
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        int lat, w0;
        logic [7:0] rd;
        w0 = wr_pulses;
        cpu_access(1'b1, 22'h380010, 8'hA5, lat, rd);
        compared++;
        if (lat !== 2) begin mismatched++; $display("FAIL wr_latency: got %0d want 2", lat); end
        compared++;
        if (wr_pulses - w0 !== 1) begin mismatched++; $display("FAIL wr_pulse: got %0d want 1", wr_pulses - w0); end
        compared++;
        if ({mem_addr, mem_d} !== {22'h380010, 8'hA5}) begin
            mismatched++;
            $display("FAIL bus_hold: got %h/%h want 380010/a5", mem_addr, mem_d);
        end
        cpu_access(1'b0, 22'h380010, 8'h00, lat, rd);
        compared++;
        if (lat !== 4) begin mismatched++; $display("FAIL rd_latency: got %0d want 4", lat); end
        compared++;
        if (rd !== 8'hA5) begin mismatched++; $display("FAIL rd_after_wr: got %h want a5", rd); end
    endtask

    task automatic test_ppu_priority();
        int pc, cc;
        pc = -1; cc = -1;
        cpu_we = 1'b0; cpu_addr = 22'h380020; cpu_req = 1'b1;
        ppu_we = 1'b0; ppu_addr = 22'h200040; ppu_req = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (ppu_ack) begin pc = i; ppu_req = 1'b0; end
            if (cpu_ack) begin cc = i; cpu_req = 1'b0; end
            if (pc >= 0 && cc >= 0) break;
        end
        cpu_req = 1'b0; ppu_req = 1'b0;
        compared++;
        if (pc !== 4) begin mismatched++; $display("FAIL prio_ppu_ack: got %0d want 4", pc); end
        compared++;
        if (cc !== 8) begin mismatched++; $display("FAIL prio_cpu_ack: got %0d want 8", cc); end
        compared++;
        if ({ppu_rdata, cpu_rdata} !== 16'h7C1C) begin
            mismatched++;
            $display("FAIL prio_rdata: got ppu=%h cpu=%h want 7c/1c", ppu_rdata, cpu_rdata);
        end
        tick();
    endtask

    task automatic test_protect();
        int lat, w0;
        logic [7:0] rd;
        w0 = wr_pulses;
        cpu_access(1'b1, 22'h001234, 8'hFF, lat, rd);
        compared++;
        if (lat !== 2) begin mismatched++; $display("FAIL prot_latency: got %0d want 2", lat); end
        compared++;
        if (wr_pulses !== w0) begin mismatched++; $display("FAIL prot_no_wr: got %0d pulses want 0", wr_pulses - w0); end
        cpu_access(1'b0, 22'h001234, 8'h00, lat, rd);
        compared++;
        if (rd !== 8'h08) begin mismatched++; $display("FAIL prot_readback: got %h want 08", rd); end
    endtask

    task automatic test_ppu_write();
        int lat, w0;
        logic [7:0] rd;
        w0 = wr_pulses;
        ppu_access(1'b1, 22'h300100, 8'h5E, lat, rd);
        compared++;
        if (lat !== 2 || wr_pulses - w0 !== 1) begin
            mismatched++;
            $display("FAIL ppu_wr: got lat=%0d pulses=%0d want 2/1", lat, wr_pulses - w0);
        end
        ppu_access(1'b0, 22'h300100, 8'h00, lat, rd);
        compared++;
        if (rd !== 8'h5E) begin mismatched++; $display("FAIL ppu_readback: got %h want 5e", rd); end
        compared++;
        if (cpu_rdata !== 8'h08) begin mismatched++; $display("FAIL cpu_rdata_hold: got %h want 08", cpu_rdata); end
    endtask

    task automatic test_load_drop();
        int lat, act;
        cpu_we = 1'b0; cpu_addr = 22'h380010; cpu_req = 1'b1;
        tick();
        load_done = 1'b0;
        lat = -1;
        for (int i = 2; i <= 40; i++) begin
            tick();
            if (cpu_ack) begin lat = i; break; end
        end
        compared++;
        if (lat !== 4 || cpu_rdata !== 8'hA5) begin
            mismatched++;
            $display("FAIL drop_inflight: got lat=%0d rdata=%h want 4/a5", lat, cpu_rdata);
        end
        cpu_req = 1'b0;
        tick();
        act = 0;
        ppu_we = 1'b0; ppu_addr = 22'h200040; ppu_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mem_rd_cpu | mem_rd_ppu | mem_wr | ppu_ack) act++;
        end
        compared++;
        if (act !== 0) begin mismatched++; $display("FAIL drop_no_grant: got %0d active want 0", act); end
        load_done = 1'b1;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (ppu_ack) begin lat = i; break; end
        end
        compared++;
        if (lat !== 4 || ppu_rdata !== 8'h7C) begin
            mismatched++;
            $display("FAIL drop_resume: got lat=%0d rdata=%h want 4/7c", lat, ppu_rdata);
        end
        ppu_req = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [7:0] seq;
        int n, cd, pd, last;
        seq = 8'h0; n = 0; cd = 0; pd = 0; last = -1;
        r_cpu_we = 1'b0; r_cpu_addr = 22'h380030; r_cpu_req = 1'b1;
        r_ppu_we = 1'b0; r_ppu_addr = 22'h200050; r_ppu_req = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (r_ppu_ack) begin
                seq = {seq[6:0], 1'b1}; n++; pd++; last = i;
                if (pd == 4) r_ppu_req = 1'b0;
            end
            if (r_cpu_ack) begin
                seq = {seq[6:0], 1'b0}; n++; cd++; last = i;
                if (cd == 4) r_cpu_req = 1'b0;
            end
            if (n >= 8) break;
        end
        r_cpu_req = 1'b0; r_ppu_req = 1'b0;
        compared++;
        if (seq !== 8'hAA || n !== 8) begin
            mismatched++;
            $display("FAIL rr_order: got seq=%h n=%0d want aa/8", seq, n);
        end
        compared++;
        if (last !== 32) begin mismatched++; $display("FAIL rr_throughput: got last ack %0d want 32", last); end
        compared++;
        if ({r_cpu_rdata, r_ppu_rdata} !== 16'h0C6C) begin
            mismatched++;
            $display("FAIL rr_rdata: got cpu=%h ppu=%h want 0c/6c", r_cpu_rdata, r_ppu_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [7:0] rd;
        cpu_we = 1'b0; cpu_addr = 22'h380010; cpu_req = 1'b1;
        tick();
        tick();
        compared++;
        if (mem_rd_cpu !== 1'b1 || dbg_state !== ST_RD) begin
            mismatched++;
            $display("FAIL mid_rd_active: got rd=%b state=%0d want 1/1", mem_rd_cpu, dbg_state);
        end
        #2;
        reset_n = 1'b0;
        #1;
        compared++;
        if ({mem_rd_cpu, mem_rd_ppu, mem_wr, cpu_ack, ppu_ack} !== 5'b0 || dbg_state !== ST_IDLE) begin
            mismatched++;
            $display("FAIL mid_reset_clear: got %b state=%0d want 00000/0",
                     {mem_rd_cpu, mem_rd_ppu, mem_wr, cpu_ack, ppu_ack}, dbg_state);
        end
        cpu_req = 1'b0;
        tick();
        compared++;
        if (cpu_ack !== 1'b0) begin mismatched++; $display("FAIL mid_no_ack: got %b want 0", cpu_ack); end
        reset_n = 1'b1;
        tick();
        cpu_access(1'b0, 22'h380010, 8'h00, lat, rd);
        compared++;
        if (lat !== 4 || rd !== 8'hA5) begin
            mismatched++;
            $display("FAIL mid_recover: got lat=%0d rdata=%h want 4/a5", lat, rd);
        end
    endtask

    initial begin
        compared = 0; mismatched = 0; wr_pulses = 0;
        reset_n = 1'b0; load_done = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 22'h0; cpu_wdata = 8'h0;
        ppu_req = 1'b0; ppu_we = 1'b0; ppu_addr = 22'h0; ppu_wdata = 8'h0;
        r_cpu_req = 1'b0; r_cpu_we = 1'b0; r_cpu_addr = 22'h0; r_cpu_wdata = 8'h0;
        r_ppu_req = 1'b0; r_ppu_we = 1'b0; r_ppu_addr = 22'h0; r_ppu_wdata = 8'h0;

        test_reset();
        test_load_gate();
        test_write_read();
        test_ppu_priority();
        test_protect();
        test_ppu_write();
        test_load_drop();
        test_round_robin();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
